// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Tracks a stream of words from an 8-bit Fibonacci shift generator whose
// step is next(w) = {w[6:0], w[7]^w[5]^w[4]^w[3]}. The checker seeds its
// predictor from one word (HUNT), confirms LOCK_CNT consecutive correct
// predictions (SYNC), then flywheels its own prediction while LOCKED. Each
// mismatch seen while LOCKED pulses `error` and bumps a saturating 16-bit
// counter. LOSS_CNT consecutive mismatches while LOCKED drop back to SYNC,
// reseeded from the word that caused the drop.
//
// Optional feature, macro LFSR_CHECKER_ZERO_DETECT_EN:
//   defined   - a valid all-zero word pulses `stuck` and forces HUNT; it is
//               not a mismatch and is never counted.
//   undefined - `stuck` is tied low and 00 is ordinary data (next(00)=00).
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT = 4,  // matches needed to lock, 1..15
  parameter int LOSS_CNT = 3   // consecutive misses that drop lock, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [7:0]  data_in,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        error,
  output logic [15:0] err_count,
  output logic        stuck
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Thresholds widened by one bit so run+1 / miss+1 never wrap before the
  // comparison, even for the maximum parameter value of 15.
  localparam logic [4:0] LOCK_THR = 5'(LOCK_CNT);
  localparam logic [4:0] LOSS_THR = 5'(LOSS_CNT);

  // Generator step: shift left, feedback from taps 7, 5, 4, 3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] w);
    return {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  expected, expected_nxt;
  logic [3:0]  run, run_nxt;
  logic [3:0]  miss, miss_nxt;
  logic        error_nxt;
  logic [15:0] err_count_nxt;
  logic [15:0] cnt_base;
  logic [4:0]  run_inc;
  logic [4:0]  miss_inc;
  logic        word_match;

`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  logic        stuck_nxt;
  logic        zero_word;

  assign zero_word = (data_in == 8'h00);
`endif

  assign run_inc    = {1'b0, run} + 5'd1;
  assign miss_inc   = {1'b0, miss} + 5'd1;
  assign word_match = (data_in == expected);

  // clr_cnt acts first, so a mismatch in the same cycle counts from zero.
  assign cnt_base   = clr_cnt ? 16'h0000 : err_count;

  // Next-state, predictor and counter update for one received word.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no
    // path leaves it unassigned; that is what keeps latches out of here.
    state_nxt     = state;
    expected_nxt  = expected;
    run_nxt       = run;
    miss_nxt      = miss;
    error_nxt     = 1'b0;
    err_count_nxt = cnt_base;
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
    stuck_nxt     = 1'b0;
`endif

    if (valid) begin
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
      if (zero_word) begin
        // A dead generator: abandon tracking without charging a mismatch.
        stuck_nxt = 1'b1;
        state_nxt = HUNT;
        run_nxt   = 4'd0;
        miss_nxt  = 4'd0;
      end else
`endif
      begin
        unique case (state)
          HUNT: begin
            expected_nxt = lfsr_next(data_in);
            run_nxt      = 4'd0;
            state_nxt    = SYNC;
          end

          SYNC: begin
            // Either way the prediction follows the received word.
            expected_nxt = lfsr_next(data_in);
            if (word_match) begin
              run_nxt = run_inc[3:0];
              if (run_inc == LOCK_THR) begin
                state_nxt = LOCKED;
                miss_nxt  = 4'd0;
              end
            end else begin
              run_nxt = 4'd0;
            end
          end

          LOCKED: begin
            if (word_match) begin
              miss_nxt     = 4'd0;
              expected_nxt = lfsr_next(expected);
            end else begin
              error_nxt     = 1'b1;
              err_count_nxt = (cnt_base == 16'hFFFF) ? 16'hFFFF
                                                     : cnt_base + 16'd1;
              miss_nxt      = miss_inc[3:0];
              if (miss_inc == LOSS_THR) begin
                // Too many misses: resynchronise on the received word.
                state_nxt    = SYNC;
                expected_nxt = lfsr_next(data_in);
                run_nxt      = 4'd0;
              end else begin
                // Flywheel: keep predicting from our own sequence.
                expected_nxt = lfsr_next(expected);
              end
            end
          end

          default: begin
            state_nxt = HUNT;
            run_nxt   = 4'd0;
            miss_nxt  = 4'd0;
          end
        endcase
      end
    end
  end

  // State, predictor and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      expected  <= 8'h00;
      run       <= 4'd0;
      miss      <= 4'd0;
      locked    <= 1'b0;
      error     <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // values computed from the same pre-edge state.
      state     <= state_nxt;
      expected  <= expected_nxt;
      run       <= run_nxt;
      miss      <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      error     <= error_nxt;
      err_count <= err_count_nxt;
    end
  end

`ifdef LFSR_CHECKER_ZERO_DETECT_EN
  // One-cycle pulse for an all-zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck <= 1'b0;
    end else begin
      stuck <= stuck_nxt;
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Main instance (default parameters) is compared every cycle against a
// behavioural model of the acquire/track rules. A second instance with
// LOSS_CNT=15 is used to walk err_count into saturation cheaply.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        valid;
  logic [7:0]  data_in;
  logic        clr_cnt;
  logic        locked;
  logic        error;
  logic [15:0] err_count;
  logic        stuck;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_clr;
  logic        s_locked;
  logic        s_error;
  logic [15:0] s_err_count;
  logic        s_stuck;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .data_in   (data_in),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .error     (error),
    .err_count (err_count),
    .stuck     (stuck)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(15)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (s_valid),
    .data_in   (s_data),
    .clr_cnt   (s_clr),
    .locked    (s_locked),
    .error     (s_error),
    .err_count (s_err_count),
    .stuck     (s_stuck)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_LOCK = 4;
  localparam int M_LOSS = 3;
  localparam int PH_HUNT = 0, PH_SYNC = 1, PH_LOCK = 2;

  int         m_phase;
  logic [7:0] m_exp;
  int         m_run, m_miss, m_cnt;
  bit         m_err, m_stuck;

  // Generator step written as shift plus tap parity.
  function automatic logic [7:0] gen_next(input logic [7:0] w);
    logic [7:0] sh;
    sh = w << 1;
    return sh | 8'($countones(w & 8'hB8) % 2);
  endfunction

  task automatic m_reset();
    m_phase = PH_HUNT; m_exp = 8'h00; m_run = 0; m_miss = 0;
    m_cnt = 0; m_err = 0; m_stuck = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    int cnt;
    cnt     = c ? 0 : m_cnt;
    m_err   = 0;
    m_stuck = 0;
    if (v) begin
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
      if (d == 8'h00) begin
        m_stuck = 1; m_phase = PH_HUNT; m_run = 0; m_miss = 0;
      end else
`endif
      if (m_phase == PH_HUNT) begin
        m_exp = gen_next(d); m_run = 0; m_phase = PH_SYNC;
      end else if (m_phase == PH_SYNC) begin
        if (d == m_exp) begin
          m_run++;
          if (m_run == M_LOCK) begin m_phase = PH_LOCK; m_miss = 0; end
        end else begin
          m_run = 0;
        end
        m_exp = gen_next(d);
      end else begin
        if (d == m_exp) begin
          m_miss = 0; m_exp = gen_next(m_exp);
        end else begin
          m_err = 1;
          cnt   = (cnt >= 65535) ? 65535 : cnt + 1;
          m_miss++;
          if (m_miss == M_LOSS) begin
            m_phase = PH_SYNC; m_exp = gen_next(d); m_run = 0;
          end else begin
            m_exp = gen_next(m_exp);
          end
        end
      end
    end
    m_cnt = cnt;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".locked"},    locked,    (m_phase == PH_LOCK));
    check({tag, ".error"},     error,     m_err);
    check({tag, ".err_count"}, err_count, m_cnt);
    check({tag, ".stuck"},     stuck,     m_stuck);
  endtask

  // One word (or idle cycle) into the main instance, checked after the edge.
  task automatic drive(input bit v, input logic [7:0] d, input bit c,
                       input string tag);
    valid = v; data_in = d; clr_cnt = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0; data_in = 8'h00; clr_cnt = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_clr = 1'b0;
    #12;
    m_reset();
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acquire_a5(input string tag);
    drive(1, 8'hA5, 0, tag);
    drive(1, 8'h4A, 0, tag);
    drive(1, 8'h95, 0, tag);
    drive(1, 8'h2A, 0, tag);
    drive(1, 8'h54, 0, tag);
  endtask

  task automatic s_drive(input logic [7:0] d, input bit c);
    s_valid = 1'b1; s_data = d; s_clr = c;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0] chain;
    logic [7:0] s_exp;
    logic [7:0] bad;
    int         s_cnt;
    int         prev_cnt;
    int         mode;

    do_reset();

    // Basic acquire: A5 seeds, four matches lock.
    acquire_a5("acq");
    check("acq.lock_after_54", locked, 1);
    check("acq.count_zero", err_count, 0);

    // Single corrupted word (FF instead of A9), then 53 realigns.
    drive(1, 8'hFF, 0, "one_miss");
    check("one_miss.error", error, 1);
    check("one_miss.count", err_count, 1);
    drive(1, 8'h53, 0, "one_miss_rec");
    check("one_miss_rec.locked", locked, 1);
    check("one_miss_rec.error", error, 0);

    // Idle cycles change nothing but may clear the count.
    drive(0, 8'h12, 0, "idle");
    drive(0, 8'h34, 1, "idle_clr");
    check("idle_clr.count", err_count, 0);

    // Three consecutive misses drop lock, reseeding from FF.
    drive(1, 8'hFF, 0, "loss1");
    drive(1, 8'hFF, 0, "loss2");
    check("loss2.still_locked", locked, 1);
    drive(1, 8'hFF, 0, "loss3");
    check("loss3.error", error, 1);
    check("loss3.count", err_count, 3);
    check("loss3.unlocked", locked, 0);
    // Seeded from FF: four words following FF relock.
    chain = gen_next(8'hFF);
    for (int i = 0; i < 4; i++) begin
      drive(1, chain, 0, "reseed_ff");
      chain = gen_next(chain);
    end
    check("reseed_ff.relock", locked, 1);

    // Corrupted word during SYNC reseeds silently.
    do_reset();
    drive(1, 8'hA5, 0, "sync_miss");
    drive(1, 8'h4A, 0, "sync_miss");
    drive(1, 8'h33, 0, "sync_miss");
    check("sync_miss.no_error", error, 0);
    drive(1, 8'h2A, 0, "sync_miss");
    drive(1, 8'h54, 0, "sync_miss");
    check("sync_miss.no_lock", locked, 0);
    chain = gen_next(8'h54);
    for (int i = 0; i < 4; i++) begin
      drive(1, chain, 0, "sync_chain");
      chain = gen_next(chain);
    end
    check("sync_chain.locked", locked, 1);
    check("sync_chain.count", err_count, 0);

    // All-zero word while locked.
    do_reset();
    acquire_a5("zero");
    prev_cnt = err_count;
    drive(1, 8'h00, 0, "zero_word");
`ifdef LFSR_CHECKER_ZERO_DETECT_EN
    check("zero_word.stuck", stuck, 1);
    check("zero_word.locked", locked, 0);
    check("zero_word.count", err_count, prev_cnt);
`else
    check("zero_word.error", error, 1);
    check("zero_word.count", err_count, prev_cnt + 1);
    check("zero_word.stuck", stuck, 0);
`endif

    // clr_cnt together with a counted mismatch.
    do_reset();
    acquire_a5("clr");
    drive(1, 8'hFF, 0, "clr_pre");
    drive(1, 8'h53, 0, "clr_pre");
    drive(1, 8'hEE, 1, "clr_and_miss");
    check("clr_and_miss.count", err_count, 1);

    // Randomised traffic against the model.
    chain = 8'(($urandom_range(1, 255)));
    for (int i = 0; i < 1500; i++) begin
      mode = $urandom_range(0, 99);
      if (mode < 65) begin
        drive(1, chain, ($urandom_range(0, 49) == 0), "rnd_good");
        chain = gen_next(chain);
      end else if (mode < 77) begin
        drive(1, 8'($urandom), 0, "rnd_bad");
        chain = gen_next(chain);
      end else if (mode < 87) begin
        drive(0, 8'($urandom), ($urandom_range(0, 3) == 0), "rnd_idle");
      end else if (mode < 90) begin
        drive(1, 8'h00, 0, "rnd_zero");
      end else if (mode < 94) begin
        drive(1, chain, 1, "rnd_clr");
        chain = gen_next(chain);
      end else begin
        chain = 8'($urandom_range(1, 255));
        drive(1, chain, 0, "rnd_jump");
        chain = gen_next(chain);
      end
    end

    // Saturation on the LOSS_CNT=15 instance: 14 misses then a match.
    s_exp = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      s_drive(s_exp, 0);
      s_exp = gen_next(s_exp);
    end
    check("sat.locked", s_locked, 1);
    s_cnt = 0;
    while (s_cnt < 65535) begin
      for (int k = 0; k < 14 && s_cnt < 65535; k++) begin
        bad = s_exp ^ 8'h01;
        if (bad == 8'h00) bad = s_exp ^ 8'h02;
        s_drive(bad, 0);
        s_exp = gen_next(s_exp);
        s_cnt++;
      end
      s_drive(s_exp, 0);
      s_exp = gen_next(s_exp);
    end
    check("sat.count_max", s_err_count, 16'hFFFF);
    check("sat.still_locked", s_locked, 1);
    s_drive(s_exp ^ 8'h01, 0);
    s_exp = gen_next(s_exp);
    check("sat.hold_max", s_err_count, 16'hFFFF);
    check("sat.error_at_max", s_error, 1);
    s_drive(s_exp ^ 8'h01, 1);
    check("sat.clr_and_miss", s_err_count, 1);

    // Asynchronous reset mid-stream.
    do_reset();
    acquire_a5("async");
    drive(1, 8'hFF, 0, "async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async.locked", locked, 0);
    check("async.error", error, 0);
    check("async.count", err_count, 0);
    check("async.stuck", stuck, 0);
    check("async.sat_count", s_err_count, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Reacquire needs a seed plus LOCK_CNT matches again.
    drive(1, 8'hA9, 0, "reacq");
    drive(1, 8'h53, 0, "reacq");
    drive(1, gen_next(8'h53), 0, "reacq");
    drive(1, gen_next(gen_next(8'h53)), 0, "reacq");
    check("reacq.not_yet", locked, 0);
    drive(1, gen_next(gen_next(gen_next(8'h53))), 0, "reacq");
    check("reacq.locked", locked, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
